// File: rtl/arvi_bus_pkg.sv
// Shared types for the IM/DM memory-port arbiter.
//   arb_state_t : grant FSM states
//   req_id_t    : requester identity, used for round-robin history
//   BYTE_EN_W   : bus byte-enable width
package arvi_bus_pkg;

    localparam int BYTE_EN_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IM = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of all IM, DM and memory-bus signals around the arbiter.
//   slave  : arbiter view (takes requests and bus response, drives bus and replies)
//   master : environment view (core fetch/LSU plus memory interconnect)
// Signal names keep the i_/o_ prefixes as seen from the arbiter.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    import arvi_bus_pkg::*;

    // instruction fetch
    logic                 i_im_rd;
    logic [XLEN-1:0]      i_im_addr;
    logic [XLEN-1:0]      o_im_rdata;
    logic                 o_im_ready;
    logic                 o_im_err;
    // data memory
    logic                 i_dm_rd;
    logic                 i_dm_wen;
    logic [XLEN-1:0]      i_dm_addr;
    logic [XLEN-1:0]      i_dm_wdata;
    logic [BYTE_EN_W-1:0] i_dm_byte_en;
    logic [XLEN-1:0]      o_dm_rdata;
    logic                 o_dm_ready;
    logic                 o_dm_err;
    // shared memory bus
    logic [XLEN-1:0]      o_mem_addr;
    logic [XLEN-1:0]      o_mem_wdata;
    logic [BYTE_EN_W-1:0] o_mem_byte_en;
    logic                 o_mem_wen;
    logic                 o_mem_rd;
    logic [XLEN-1:0]      i_mem_rdata;
    logic                 i_mem_ready;

    modport slave (
        input  i_im_rd, i_im_addr,
        output o_im_rdata, o_im_ready, o_im_err,
        input  i_dm_rd, i_dm_wen, i_dm_addr, i_dm_wdata, i_dm_byte_en,
        output o_dm_rdata, o_dm_ready, o_dm_err,
        output o_mem_addr, o_mem_wdata, o_mem_byte_en, o_mem_wen, o_mem_rd,
        input  i_mem_rdata, i_mem_ready
    );

    modport master (
        output i_im_rd, i_im_addr,
        input  o_im_rdata, o_im_ready, o_im_err,
        output i_dm_rd, i_dm_wen, i_dm_addr, i_dm_wdata, i_dm_byte_en,
        input  o_dm_rdata, o_dm_ready, o_dm_err,
        input  o_mem_addr, o_mem_wdata, o_mem_byte_en, o_mem_wen, o_mem_rd,
        output i_mem_rdata, i_mem_ready
    );

endinterface

// File: rtl/arb_watchdog.sv
// Per-transaction watchdog counter.
//   i_clk, i_rst : clock, synchronous active-low reset
//   i_clr        : zero the counter (held while the arbiter is idle)
//   i_en         : count one waiting grant cycle
//   o_timeout    : counter has reached TIMEOUT-1, i.e. this is the last allowed cycle
module arb_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clr) cnt <= '0;
        else if (i_en)       cnt <= cnt + TO_W'(1);
    end

    // Decoded from the register only, so it never depends on i_mem_ready.
    assign o_timeout = (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch (IM)
// and data memory (DM). Registered grant, round-robin on contention,
// watchdog timeout, and abort when the granted requester drops its request.
//   i_clk, i_rst : clock, synchronous active-low reset
//   bus          : mem_port_arbiter_if.slave carrying IM, DM and memory-bus signals
module mem_port_arbiter
    import arvi_bus_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mem_port_arbiter_if.slave     bus
);

    arb_state_t state, state_nxt;
    req_id_t    last_grant, last_grant_nxt;
    logic       im_req, dm_req;
    logic       timeout;

    assign im_req = bus.i_im_rd;
    assign dm_req = bus.i_dm_rd | bus.i_dm_wen;

    // Counter is held at zero through the mandatory IDLE bubble, so every
    // grant starts from a clean count.
    arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (state == IDLE),
        .i_en      (state != IDLE),
        .o_timeout (timeout)
    );

    assign bus.o_im_rdata = bus.i_mem_rdata;
    assign bus.o_dm_rdata = bus.i_mem_rdata;

    always_comb begin
        state_nxt         = state;
        last_grant_nxt    = last_grant;
        bus.o_mem_addr    = {XLEN{1'b0}};
        bus.o_mem_wdata   = {XLEN{1'b0}};
        bus.o_mem_byte_en = '0;
        bus.o_mem_wen     = 1'b0;
        bus.o_mem_rd      = 1'b0;
        bus.o_im_ready    = 1'b0;
        bus.o_im_err      = 1'b0;
        bus.o_dm_ready    = 1'b0;
        bus.o_dm_err      = 1'b0;

        case (state)
            IDLE: begin
                // On contention, hand the bus to whoever did not have it last.
                if (dm_req && (!im_req || last_grant == REQ_IM)) state_nxt = GNT_D;
                else if (im_req)                                 state_nxt = GNT_I;
            end

            GNT_I: begin
                bus.o_mem_addr    = bus.i_im_addr;
                bus.o_mem_byte_en = '1;
                // Strobe drops on the timeout cycle; gated by registered state only.
                bus.o_mem_rd      = im_req & ~timeout;
                if (!im_req) begin
                    state_nxt = IDLE;
                end else if (bus.i_mem_ready) begin
                    bus.o_im_ready = 1'b1;
                    state_nxt      = IDLE;
                    last_grant_nxt = REQ_IM;
                end else if (timeout) begin
                    bus.o_im_err   = 1'b1;
                    state_nxt      = IDLE;
                    last_grant_nxt = REQ_IM;
                end
            end

            GNT_D: begin
                bus.o_mem_addr    = bus.i_dm_addr;
                bus.o_mem_wdata   = bus.i_dm_wdata;
                bus.o_mem_byte_en = bus.i_dm_byte_en;
                // Write takes priority when both DM strobes are set.
                bus.o_mem_wen     = bus.i_dm_wen & ~timeout;
                bus.o_mem_rd      = bus.i_dm_rd & ~bus.i_dm_wen & ~timeout;
                if (!dm_req) begin
                    state_nxt = IDLE;
                end else if (bus.i_mem_ready) begin
                    bus.o_dm_ready = 1'b1;
                    state_nxt      = IDLE;
                    last_grant_nxt = REQ_DM;
                end else if (timeout) begin
                    bus.o_dm_err   = 1'b1;
                    state_nxt      = IDLE;
                    last_grant_nxt = REQ_DM;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= IDLE;
            last_grant <= REQ_IM;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.XLEN(32)) bus ();

    mem_port_arbiter #(
        .XLEN    (32),
        .TIMEOUT (4),
        .TO_W    (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst              = 1'b0;
        bus.i_im_rd      = 1'b0;
        bus.i_im_addr    = '0;
        bus.i_dm_rd      = 1'b0;
        bus.i_dm_wen     = 1'b0;
        bus.i_dm_addr    = '0;
        bus.i_dm_wdata   = '0;
        bus.i_dm_byte_en = '0;
        bus.i_mem_rdata  = '0;
        bus.i_mem_ready  = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rd",    32'(bus.o_mem_rd),      0);
        chk("rst_wen",   32'(bus.o_mem_wen),     0);
        chk("rst_addr",  bus.o_mem_addr,         0);
        chk("rst_be",    32'(bus.o_mem_byte_en), 0);
        chk("rst_imrdy", 32'(bus.o_im_ready),    0);
        chk("rst_dmerr", 32'(bus.o_dm_err),      0);
        rst = 1'b1;

        // IM only, ready two cycles after the strobe
        @(negedge clk); bus.i_im_rd = 1'b1; bus.i_im_addr = 32'h100; #1;
        chk("t1_idle_rd", 32'(bus.o_mem_rd), 0);
        @(negedge clk); #1;
        chk("t1_rd",    32'(bus.o_mem_rd),      1);
        chk("t1_addr",  bus.o_mem_addr,         32'h100);
        chk("t1_be",    32'(bus.o_mem_byte_en), 32'hF);
        chk("t1_wen",   32'(bus.o_mem_wen),     0);
        chk("t1_rdy0",  32'(bus.o_im_ready),    0);
        @(negedge clk); #1;
        chk("t1_rd2",   32'(bus.o_mem_rd),      1);
        @(negedge clk); bus.i_mem_ready = 1'b1; bus.i_mem_rdata = 32'hDEADBEEF; #1;
        chk("t1_imrdy",  32'(bus.o_im_ready), 1);
        chk("t1_rdata",  bus.o_im_rdata,      32'hDEADBEEF);
        chk("t1_dmrdy",  32'(bus.o_dm_ready), 0);
        chk("t1_dmerr",  32'(bus.o_dm_err),   0);
        @(negedge clk); bus.i_im_rd = 1'b0; bus.i_mem_ready = 1'b0; #1;
        chk("t1_done_rd",  32'(bus.o_mem_rd),   0);
        chk("t1_done_rdy", 32'(bus.o_im_ready), 0);

        // contention: last grant IM -> DM, then IM, then DM again
        @(negedge clk);
        bus.i_dm_wen = 1'b1; bus.i_dm_addr = 32'h200; bus.i_dm_wdata = 32'h55; bus.i_dm_byte_en = 4'b0010;
        bus.i_im_rd  = 1'b1; bus.i_im_addr = 32'h104;
        @(negedge clk); #1;
        chk("t2_d_wen",   32'(bus.o_mem_wen),     1);
        chk("t2_d_rd",    32'(bus.o_mem_rd),      0);
        chk("t2_d_addr",  bus.o_mem_addr,         32'h200);
        chk("t2_d_wdata", bus.o_mem_wdata,        32'h55);
        chk("t2_d_be",    32'(bus.o_mem_byte_en), 32'h2);
        bus.i_mem_ready = 1'b1; #1;
        chk("t2_d_rdy",   32'(bus.o_dm_ready), 1);
        chk("t2_d_imrdy", 32'(bus.o_im_ready), 0);
        @(negedge clk); bus.i_mem_ready = 1'b0; #1;
        chk("t2_bub_wen", 32'(bus.o_mem_wen), 0);
        chk("t2_bub_rd",  32'(bus.o_mem_rd),  0);
        @(negedge clk); #1;
        chk("t2_i_rd",   32'(bus.o_mem_rd),      1);
        chk("t2_i_addr", bus.o_mem_addr,         32'h104);
        chk("t2_i_be",   32'(bus.o_mem_byte_en), 32'hF);
        chk("t2_i_wen",  32'(bus.o_mem_wen),     0);
        bus.i_mem_ready = 1'b1; bus.i_mem_rdata = 32'h12345678; #1;
        chk("t2_i_rdy",   32'(bus.o_im_ready), 1);
        chk("t2_i_rdata", bus.o_im_rdata,      32'h12345678);
        chk("t2_i_dmrdy", 32'(bus.o_dm_ready), 0);
        @(negedge clk); bus.i_mem_ready = 1'b0; #1;
        chk("t2_bub2_rd", 32'(bus.o_mem_rd), 0);
        @(negedge clk); #1;
        chk("t2_d2_wen",  32'(bus.o_mem_wen), 1);
        chk("t2_d2_addr", bus.o_mem_addr,     32'h200);
        bus.i_mem_ready = 1'b1; #1;
        chk("t2_d2_rdy",  32'(bus.o_dm_ready), 1);
        @(negedge clk);
        bus.i_mem_ready = 1'b0; bus.i_im_rd = 1'b0; bus.i_dm_wen = 1'b0; #1;
        chk("t2_bub3_wen", 32'(bus.o_mem_wen), 0);
        // third concurrent pair after a DM grant -> IM first
        @(negedge clk);
        bus.i_im_rd = 1'b1; bus.i_im_addr = 32'h108; bus.i_dm_rd = 1'b1; bus.i_dm_addr = 32'h204;
        @(negedge clk); #1;
        chk("t2_p3_rd",   32'(bus.o_mem_rd), 1);
        chk("t2_p3_addr", bus.o_mem_addr,    32'h108);
        bus.i_mem_ready = 1'b1; #1;
        chk("t2_p3_rdy",  32'(bus.o_im_ready), 1);
        @(negedge clk); bus.i_mem_ready = 1'b0; bus.i_im_rd = 1'b0; bus.i_dm_rd = 1'b0;

        // timeout: DM write held, memory never ready
        @(negedge clk);
        bus.i_dm_wen = 1'b1; bus.i_dm_addr = 32'h210; bus.i_dm_wdata = 32'hA5; bus.i_dm_byte_en = 4'hF;
        for (int g = 1; g <= 3; g++) begin
            @(negedge clk); #1;
            chk($sformatf("t3_wen_g%0d", g), 32'(bus.o_mem_wen), 1);
            chk($sformatf("t3_err_g%0d", g), 32'(bus.o_dm_err),  0);
        end
        @(negedge clk); #1;
        chk("t3_err",   32'(bus.o_dm_err),   1);
        chk("t3_wen0",  32'(bus.o_mem_wen),  0);
        chk("t3_rdy0",  32'(bus.o_dm_ready), 0);
        chk("t3_imerr", 32'(bus.o_im_err),   0);
        @(negedge clk); bus.i_dm_wen = 1'b0; #1;
        chk("t3_after_err", 32'(bus.o_dm_err),  0);
        chk("t3_after_wen", 32'(bus.o_mem_wen), 0);

        // ready coincides with the timeout cycle
        @(negedge clk); bus.i_dm_wen = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("t4_wen", 32'(bus.o_mem_wen), 1);
        end
        @(negedge clk); bus.i_mem_ready = 1'b1; #1;
        chk("t4_rdy", 32'(bus.o_dm_ready), 1);
        chk("t4_err", 32'(bus.o_dm_err),   0);
        @(negedge clk); bus.i_mem_ready = 1'b0; bus.i_dm_wen = 1'b0; #1;
        chk("t4_after_rdy", 32'(bus.o_dm_ready), 0);

        // DM read withdrawn one cycle after the grant
        @(negedge clk); bus.i_dm_rd = 1'b1; bus.i_dm_addr = 32'h400;
        @(negedge clk); #1;
        chk("t5_rd",   32'(bus.o_mem_rd), 1);
        chk("t5_addr", bus.o_mem_addr,    32'h400);
        @(negedge clk); bus.i_dm_rd = 1'b0; #1;
        chk("t5_abort_rd",  32'(bus.o_mem_rd),   0);
        chk("t5_abort_rdy", 32'(bus.o_dm_ready), 0);
        @(negedge clk); bus.i_mem_ready = 1'b1; #1;
        chk("t5_late_dmrdy", 32'(bus.o_dm_ready), 0);
        chk("t5_late_imrdy", 32'(bus.o_im_ready), 0);
        chk("t5_late_rd",    32'(bus.o_mem_rd),   0);

        // reset in the middle of an IM grant; last grant returns to IM
        @(negedge clk); bus.i_mem_ready = 1'b0; bus.i_im_rd = 1'b1; bus.i_im_addr = 32'h180;
        @(negedge clk); #1;
        chk("t6_rd",   32'(bus.o_mem_rd), 1);
        chk("t6_addr", bus.o_mem_addr,    32'h180);
        rst = 1'b0;
        @(negedge clk); rst = 1'b1; bus.i_dm_rd = 1'b1; bus.i_dm_addr = 32'h500; #1;
        chk("t6_rst_rd",   32'(bus.o_mem_rd),      0);
        chk("t6_rst_wen",  32'(bus.o_mem_wen),     0);
        chk("t6_rst_addr", bus.o_mem_addr,         0);
        chk("t6_rst_be",   32'(bus.o_mem_byte_en), 0);
        chk("t6_rst_rdy",  32'(bus.o_im_ready),    0);
        @(negedge clk); #1;
        chk("t6_d_rd",    32'(bus.o_mem_rd), 1);
        chk("t6_d_addr",  bus.o_mem_addr,    32'h500);
        chk("t6_d_imrdy", 32'(bus.o_im_ready), 0);
        bus.i_mem_ready = 1'b1; bus.i_mem_rdata = 32'hCAFEF00D; #1;
        chk("t6_d_rdy",   32'(bus.o_dm_ready), 1);
        chk("t6_d_rdata", bus.o_dm_rdata,      32'hCAFEF00D);
        chk("t6_d_imrdy2", 32'(bus.o_im_ready), 0);
        @(negedge clk); bus.i_mem_ready = 1'b0; bus.i_im_rd = 1'b0; bus.i_dm_rd = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
